// File: rtl/tea_stream_fifo.sv
// ---------------------------------------------------------------------------
// tea_stream_fifo
//
// Purpose: Avalon-ST buffer between the TEA stage and a downstream consumer.
// The upstream pipeline cannot cancel words already in flight. Every valid
// sink word is therefore written whatever fifo_sink_ready says.
// fifo_sink_ready is an early warning. It drops while SKID_MARGIN entries are
// still free, which leaves room for the words already in flight. A word that
// arrives when the buffer is truly full, with no pop in the same cycle, is
// dropped and recorded in overflow_flag.
// Packet framing on accepted words is checked. Violations are recorded in
// framing_error. The offending word is still stored.
//
// Optional feature: define TEA_STREAM_FIFO_STATS_EN to add the pkt_count and
// drop_count statistics outputs.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, 32..256)
//   SKID_MARGIN  free entries reserved for in-flight upstream words
//
// Ports:
//   clk                 sole clock, rising edge
//   rst                 synchronous active-high reset
//   fifo_sink_data      [31:0] sink word data
//   fifo_sink_valid     sink word valid (always written unless full)
//   fifo_sink_sop/eop   sink packet delimiters
//   fifo_sink_ready     registered backpressure to the TEA stage
//   fifo_source_data    [31:0] head word (fall-through)
//   fifo_source_valid   head word present (level > 0)
//   fifo_source_sop/eop head packet delimiters (gated by valid)
//   fifo_source_ready   consumer ready
//   err_clear           one-cycle pulse clearing sticky flags (and stats)
//   fifo_level          occupancy, 0..DEPTH
//   overflow_flag       sticky: a write was dropped
//   framing_error       sticky: packet framing violation seen
//   pkt_count           [15:0] popped eop words, wrapping (STATS_EN only)
//   drop_count          [15:0] dropped writes, saturating (STATS_EN only)
// ---------------------------------------------------------------------------
module tea_stream_fifo #(
  parameter int DEPTH       = 64,
  parameter int SKID_MARGIN = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            fifo_sink_data,
  input  logic                   fifo_sink_valid,
  input  logic                   fifo_sink_sop,
  input  logic                   fifo_sink_eop,
  output logic                   fifo_sink_ready,
  output logic [31:0]            fifo_source_data,
  output logic                   fifo_source_valid,
  output logic                   fifo_source_sop,
  output logic                   fifo_source_eop,
  input  logic                   fifo_source_ready,
  input  logic                   err_clear,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow_flag,
  output logic                   framing_error
`ifdef TEA_STREAM_FIFO_STATS_EN
  ,
  output logic [15:0]            pkt_count,
  output logic [15:0]            drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_IN_PKT
  } pkt_state_e;

  // Storage word layout: {sop, eop, data}.
  logic [33:0]   mem_q [DEPTH];

  // Pointers carry an extra MSB so that full and empty can be told apart.
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic          sink_ready_q, sink_ready_d;
  logic          overflow_q, overflow_d;
  logic          framing_q, framing_d;
  pkt_state_e    pkt_state_q, pkt_state_d;

  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic [LW:0]   free_next;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic          frame_evt;
  logic [33:0]   head;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == LW'(DEPTH));
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign pop   = (level != '0) && fifo_source_ready;
  // When the buffer is full, a pop in the same cycle frees the slot at the
  // head. The write index equals the head index in that case. The head is
  // read combinationally before the edge, so the outgoing word is not
  // corrupted.
  assign wr_en = fifo_sink_valid && (!full || pop);
  assign drop  = fifo_sink_valid && full && !pop;

  assign level_next = level + LW'(wr_en) - LW'(pop);
  assign free_next  = (LW+1)'(DEPTH) - {1'b0, level_next};

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {fifo_sink_sop, fifo_sink_eop, fifo_sink_data};
    end
  end

  // Packet framing FSM: next state and violation detection.
  always_comb begin
    pkt_state_d = pkt_state_q;
    frame_evt   = 1'b0;
    if (wr_en) begin
      if (fifo_sink_sop) begin
        frame_evt = (pkt_state_q == S_IN_PKT);
      end else begin
        frame_evt = (pkt_state_q == S_IDLE);
      end
      // A sop inside a packet restarts it. A word that is both sop and eop
      // is a single-word packet and leaves the FSM idle.
      if (fifo_sink_sop && !fifo_sink_eop) begin
        pkt_state_d = S_IN_PKT;
      end else if (fifo_sink_eop) begin
        pkt_state_d = S_IDLE;
      end
    end
  end

  // Next-state logic for pointers, ready and sticky flags. A set event
  // takes priority over err_clear in the same cycle.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + LW'(wr_en);
    rd_ptr_d     = rd_ptr_q + LW'(pop);
    sink_ready_d = (free_next > (LW+1)'(SKID_MARGIN));
    overflow_d   = overflow_q;
    framing_d    = framing_q;
    if (err_clear) begin
      overflow_d = 1'b0;
      framing_d  = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    if (frame_evt) begin
      framing_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sink_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      framing_q    <= 1'b0;
      pkt_state_q  <= S_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sink_ready_q <= sink_ready_d;
      overflow_q   <= overflow_d;
      framing_q    <= framing_d;
      pkt_state_q  <= pkt_state_d;
    end
  end

  assign fifo_sink_ready   = sink_ready_q;
  assign fifo_source_valid = (level != '0);
  assign fifo_source_data  = head[31:0];
  // Delimiters are gated so that they read 0 while the buffer is empty. The
  // storage behind the head pointer is not reset and may hold stale values.
  assign fifo_source_sop   = fifo_source_valid && head[33];
  assign fifo_source_eop   = fifo_source_valid && head[32];
  assign fifo_level        = level;
  assign overflow_flag     = overflow_q;
  assign framing_error     = framing_q;

`ifdef TEA_STREAM_FIFO_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    if (err_clear) begin
      pkt_count_d  = '0;
      drop_count_d = '0;
    end else begin
      if (pop && head[32]) begin
        pkt_count_d = pkt_count_q + 16'd1;
      end
      if (drop && (drop_count_q != 16'hFFFF)) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: doc/tea_stream_fifo.md
TEA_STREAM_FIFO -- requirements
Module: tea_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, FIFO entries; power of two, 32..256.
REQ-002 SHALL have parameter SKID_MARGIN, default 16, entries held free for in-flight upstream pipeline words.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports fifo_sink_data/valid/sop/eop  input  32/1/1/1  Avalon-ST words from the TEA stage source.
REQ-006 SHALL have port fifo_sink_ready  output  1  backpressure to the TEA stage.
REQ-007 SHALL have ports fifo_source_data/valid/sop/eop  output  32/1/1/1  Avalon-ST words to the downstream consumer.
REQ-008 SHALL have port fifo_source_ready  input  1  consumer ready.
REQ-009 SHALL have port err_clear  input  1  single-cycle pulse clearing the sticky error flags.
REQ-010 SHALL have ports fifo_level  output  clog2(DEPTH)+1  occupancy; overflow_flag  output  1; framing_error  output  1.

Function
REQ-011 SHALL write {sop,eop,data} on every cycle with fifo_sink_valid=1, independent of fifo_sink_ready, because the upstream pipeline cannot cancel in-flight words.
REQ-012 SHALL drop a write arriving when full with no simultaneous pop, and set overflow_flag on the next edge.
REQ-013 SHALL accept push and pop in the same cycle when full or non-empty, leaving fifo_level unchanged.
REQ-014 SHALL drive fifo_source_valid=1 whenever level>0, with fall-through head data: a word written at edge N is presented after edge N (no same-cycle empty bypass).
REQ-015 SHALL pop the head only when fifo_source_valid=1 and fifo_source_ready=1; data/sop/eop SHALL hold stable while valid=1 and ready=0.
REQ-016 SHALL register fifo_sink_ready = (DEPTH - level_next) > SKID_MARGIN.
REQ-017 SHALL track packet state IDLE/IN_PKT: IDLE->IN_PKT on accepted sop without eop; IN_PKT->IDLE on accepted eop; sop+eop single-word packets stay IDLE.
REQ-018 SHALL set framing_error on an accepted word with sop=1 in IN_PKT, or sop=0 in IDLE; the word is still stored; sop in IN_PKT restarts the packet.
REQ-019 SHALL clear overflow_flag and framing_error on err_clear; a same-cycle set event SHALL win over err_clear.
REQ-020 SHALL wrap read/write pointers modulo DEPTH, using an extra MSB to distinguish full from empty.

Reset
REQ-021 SHALL on rst=1 set pointers and fifo_level to 0, fifo_source_valid/sop/eop to 0, fifo_sink_ready to 0, flags to 0, packet state IDLE; storage contents are not reset.
REQ-022 SHALL drive fifo_sink_ready=1 on the first edge after rst deasserts.
REQ-023 SHALL discard all buffered words when rst asserts mid-packet; no eop is emitted for the truncated packet.

Configuration
REQ-024 SHALL, with macro TEA_STREAM_FIFO_STATS_EN defined, add outputs pkt_count (16 bit, +1 per popped eop, wrapping 0xFFFF->0) and drop_count (16 bit, +1 per dropped write, saturating at 0xFFFF), both zeroed by rst and by err_clear.
REQ-025 SHALL, without TEA_STREAM_FIFO_STATS_EN, omit both ports and counters, with all other behaviour identical.

Verification
REQ-026 SHALL cover: rst, then 4-word packet (sop on word 0, eop on word 3), source_ready=1 -> identical data/sop/eop emitted in order, first word valid one cycle after write, level returns to 0.
REQ-027 SHALL cover: DEPTH=64, source_ready=0, stream 48 words -> fifo_sink_ready drops when level reaches 48; 16 further words accepted; level=64; overflow_flag=0.
REQ-028 SHALL cover: full FIFO, source_ready=0, one more sink word -> word dropped, overflow_flag=1, level stays 64; with STATS_EN, drop_count=1; err_clear -> flag and counter 0.
REQ-029 SHALL cover: full FIFO, push and pop in the same cycle -> level stays 64, no drop, output order preserved.
REQ-030 SHALL cover: sop, sop (no eop between) -> framing_error=1, both words stored; word with sop=0 in IDLE -> framing_error=1.
REQ-031 SHALL cover: rst asserted mid-packet at level 10 -> after the edge, level=0, fifo_source_valid=0; after deassertion fifo_sink_ready=1 and a new packet flows normally.
